// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle control unit and the RV32I datapath.
// The master side is the control unit: it receives the instruction register
// and the ALU zero flag, and drives every mux select and write strobe.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic [9:0]  alu_funct;
  logic [1:0]  alu_src_a_sel;
  logic [1:0]  alu_src_b_sel;
  logic [2:0]  imm_sel;
  logic [1:0]  result_sel;
  logic        adr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        mem_write;
  logic        illegal;

  // Control unit view
  modport master (
    input  instr, zero,
    output alu_funct, alu_src_a_sel, alu_src_b_sel, imm_sel, result_sel,
           adr_sel, ir_write, pc_write, reg_write, mem_write, illegal
  );

  // Datapath view
  modport slave (
    output instr, zero,
    input  alu_funct, alu_src_a_sel, alu_src_b_sel, imm_sel, result_sel,
           adr_sel, ir_write, pc_write, reg_write, mem_write, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit. Walks each instruction through fetch,
// decode, execute, memory and writeback states, producing datapath selects,
// write strobes and the 10-bit ALU function code {jalr_mask, sub_sra, 5'b0, op3}.
// Unsupported opcodes (and branch funct3 010/011) park the unit in TRAP with a
// sticky illegal flag until reset.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    ALU_WB, BRANCH, JALR_ADDR, JUMP, UPPER, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [9:0] ALU_ADD      = 10'h000;
  localparam logic [9:0] ALU_SUB      = 10'h100;
  localparam logic [9:0] ALU_ADD_MASK = 10'h200;
  localparam logic [9:0] ALU_SLT      = 10'h002;
  localparam logic [9:0] ALU_SLTU     = 10'h003;

  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_OLD_PC = 2'd1;
  localparam logic [1:0] A_RS1    = 2'd2;
  localparam logic [1:0] A_ZERO   = 2'd3;
  localparam logic [1:0] B_RS2    = 2'd0;
  localparam logic [1:0] B_IMM    = 2'd1;
  localparam logic [1:0] B_FOUR   = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU    = 2'd0;
  localparam logic [1:0] RES_ALUOUT = 2'd1;
  localparam logic [1:0] RES_MDR    = 2'd2;

  state_t      state, next_state;
  logic        illegal_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr_bits;

  logic [9:0]  r_code, i_code, b_code;
  logic        branch_taken;
  logic        branch_bad;

  logic [9:0]  alu_funct_c;
  logic [1:0]  src_a_c, src_b_c, result_c;
  logic [2:0]  imm_c;
  logic        adr_c, ir_write_c, pc_write_c, reg_write_c, mem_write_c;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7b5          = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // ALU codes for register ops, immediate ops and branch compares; ADDI never becomes SUB
  always_comb begin
    r_code = {1'b0, funct7b5 & ((funct3 == 3'b000) || (funct3 == 3'b101)), 5'b0, funct3};
    i_code = {1'b0, funct7b5 & (funct3 == 3'b101), 5'b0, funct3};
    b_code = 10'h000;
    branch_taken = 1'b0;
    branch_bad   = 1'b0;
    case (funct3)
      3'b000: begin b_code = ALU_SUB;  branch_taken =  bus.zero; end
      3'b001: begin b_code = ALU_SUB;  branch_taken = !bus.zero; end
      3'b100: begin b_code = ALU_SLT;  branch_taken = !bus.zero; end
      3'b101: begin b_code = ALU_SLT;  branch_taken =  bus.zero; end
      3'b110: begin b_code = ALU_SLTU; branch_taken = !bus.zero; end
      3'b111: begin b_code = ALU_SLTU; branch_taken =  bus.zero; end
      default: branch_bad = 1'b1;
    endcase
  end

  // State register and sticky illegal flag, both cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      illegal_q <= (next_state == TRAP);
    end
  end

  // Next-state and Moore output decode; everything not used by a state stays 0
  always_comb begin
    next_state  = state;
    alu_funct_c = ALU_ADD;
    src_a_c     = A_PC;
    src_b_c     = B_RS2;
    imm_c       = IMM_I;
    result_c    = RES_ALU;
    adr_c       = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      FETCH: begin
        adr_c      = 1'b0;
        ir_write_c = 1'b1;
        src_a_c    = A_PC;
        src_b_c    = B_FOUR;
        result_c   = RES_ALU;
        pc_write_c = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        src_a_c = A_OLD_PC;
        src_b_c = B_IMM;
        if (opcode == OP_BRANCH)   imm_c = IMM_B;
        else if (opcode == OP_JAL) imm_c = IMM_J;
        else                       imm_c = IMM_I;
        case (opcode)
          OP_R:               next_state = EXEC_R;
          OP_I:               next_state = EXEC_I;
          OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
          OP_BRANCH:          next_state = BRANCH;
          OP_JAL:             next_state = JUMP;
          OP_JALR:            next_state = JALR_ADDR;
          OP_LUI, OP_AUIPC:   next_state = UPPER;
          default:            next_state = TRAP;
        endcase
      end
      EXEC_R: begin
        src_a_c     = A_RS1;
        src_b_c     = B_RS2;
        alu_funct_c = r_code;
        next_state  = ALU_WB;
      end
      EXEC_I: begin
        src_a_c     = A_RS1;
        src_b_c     = B_IMM;
        imm_c       = IMM_I;
        alu_funct_c = i_code;
        next_state  = ALU_WB;
      end
      MEM_ADDR: begin
        src_a_c = A_RS1;
        src_b_c = B_IMM;
        if (opcode == OP_STORE) begin
          imm_c      = IMM_S;
          next_state = MEM_WRITE;
        end else begin
          imm_c      = IMM_I;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        adr_c      = 1'b1;
        next_state = MEM_WB;
      end
      MEM_WB: begin
        result_c    = RES_MDR;
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end
      MEM_WRITE: begin
        adr_c       = 1'b1;
        mem_write_c = 1'b1;
        next_state  = FETCH;
      end
      ALU_WB: begin
        result_c    = RES_ALUOUT;
        reg_write_c = 1'b1;
        next_state  = FETCH;
      end
      BRANCH: begin
        src_a_c     = A_RS1;
        src_b_c     = B_RS2;
        alu_funct_c = b_code;
        if (branch_taken) begin
          pc_write_c = 1'b1;
          result_c   = RES_ALUOUT;
        end
        next_state = branch_bad ? TRAP : FETCH;
      end
      JALR_ADDR: begin
        src_a_c     = A_RS1;
        src_b_c     = B_IMM;
        imm_c       = IMM_I;
        alu_funct_c = ALU_ADD_MASK;
        next_state  = JUMP;
      end
      JUMP: begin
        src_a_c    = A_OLD_PC;
        src_b_c    = B_FOUR;
        result_c   = RES_ALUOUT;
        pc_write_c = 1'b1;
        next_state = ALU_WB;
      end
      UPPER: begin
        imm_c      = IMM_U;
        src_b_c    = B_IMM;
        src_a_c    = (opcode == OP_LUI) ? A_ZERO : A_OLD_PC;
        next_state = ALU_WB;
      end
      TRAP: begin
        next_state = TRAP;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  assign bus.alu_funct     = alu_funct_c;
  assign bus.alu_src_a_sel = src_a_c;
  assign bus.alu_src_b_sel = src_b_c;
  assign bus.imm_sel       = imm_c;
  assign bus.result_sel    = result_c;
  assign bus.adr_sel       = adr_c;
  assign bus.ir_write      = ir_write_c  & ~reset;
  assign bus.pc_write      = pc_write_c  & ~reset;
  assign bus.reg_write     = reg_write_c & ~reset;
  assign bus.mem_write     = mem_write_c & ~reset;
  assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: an instruction-level model builds the
// expected per-cycle output trace of each instruction, a single compare
// process checks every cycle against it, and directed instructions pin
// hand-computed values. Random instructions follow.
module tb_multicycle_control;

  typedef struct packed {
    logic [9:0] funct;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       ill;
  } rec_t;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  rec_t exp_q[$];
  rec_t seen[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of the DUT outputs as one record
  function automatic rec_t observe();
    rec_t r;
    r.funct = bus.alu_funct;
    r.a     = bus.alu_src_a_sel;
    r.b     = bus.alu_src_b_sel;
    r.imm   = bus.imm_sel;
    r.res   = bus.result_sel;
    r.adr   = bus.adr_sel;
    r.irw   = bus.ir_write;
    r.pcw   = bus.pc_write;
    r.regw  = bus.reg_write;
    r.memw  = bus.mem_write;
    r.ill   = bus.illegal;
    return r;
  endfunction

  function automatic rec_t wb_rec();
    rec_t r;
    r = '0;
    r.res  = 2'd1;
    r.regw = 1'b1;
    return r;
  endfunction

  // Instruction-level model: appends the expected cycle-by-cycle outputs of
  // one instruction to exp_q; returns 1 when the instruction ends in a trap
  function automatic bit build_trace(input logic [31:0] ins, input logic z);
    rec_t       r;
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;
    bit         trap;
    op   = ins[6:0];
    f3   = ins[14:12];
    b30  = ins[30];
    trap = 1'b0;
    r = '0; r.b = 2'd2; r.irw = 1'b1; r.pcw = 1'b1;
    exp_q.push_back(r);
    r = '0; r.a = 2'd1; r.b = 2'd1;
    r.imm = (op == 7'b1100011) ? 3'd2 : (op == 7'b1101111) ? 3'd4 : 3'd0;
    exp_q.push_back(r);
    case (op)
      7'b0110011: begin
        r = '0; r.a = 2'd2; r.b = 2'd0;
        r.funct = {7'b0, f3} + ((b30 && (f3 == 3'd0 || f3 == 3'd5)) ? 10'd256 : 10'd0);
        exp_q.push_back(r);
        exp_q.push_back(wb_rec());
      end
      7'b0010011: begin
        r = '0; r.a = 2'd2; r.b = 2'd1; r.imm = 3'd0;
        r.funct = {7'b0, f3} + ((b30 && f3 == 3'd5) ? 10'd256 : 10'd0);
        exp_q.push_back(r);
        exp_q.push_back(wb_rec());
      end
      7'b0000011: begin
        r = '0; r.a = 2'd2; r.b = 2'd1; r.imm = 3'd0;
        exp_q.push_back(r);
        r = '0; r.adr = 1'b1;
        exp_q.push_back(r);
        r = '0; r.res = 2'd2; r.regw = 1'b1;
        exp_q.push_back(r);
      end
      7'b0100011: begin
        r = '0; r.a = 2'd2; r.b = 2'd1; r.imm = 3'd1;
        exp_q.push_back(r);
        r = '0; r.adr = 1'b1; r.memw = 1'b1;
        exp_q.push_back(r);
      end
      7'b1100011: begin
        r = '0; r.a = 2'd2; r.b = 2'd0;
        case (f3)
          3'd0: begin r.funct = 10'h100; r.pcw =  z; end
          3'd1: begin r.funct = 10'h100; r.pcw = !z; end
          3'd4: begin r.funct = 10'h002; r.pcw = !z; end
          3'd5: begin r.funct = 10'h002; r.pcw =  z; end
          3'd6: begin r.funct = 10'h003; r.pcw = !z; end
          3'd7: begin r.funct = 10'h003; r.pcw =  z; end
          default: trap = 1'b1;
        endcase
        r.res = r.pcw ? 2'd1 : 2'd0;
        exp_q.push_back(r);
      end
      7'b1101111: begin
        r = '0; r.a = 2'd1; r.b = 2'd2; r.res = 2'd1; r.pcw = 1'b1;
        exp_q.push_back(r);
        exp_q.push_back(wb_rec());
      end
      7'b1100111: begin
        r = '0; r.a = 2'd2; r.b = 2'd1; r.funct = 10'h200;
        exp_q.push_back(r);
        r = '0; r.a = 2'd1; r.b = 2'd2; r.res = 2'd1; r.pcw = 1'b1;
        exp_q.push_back(r);
        exp_q.push_back(wb_rec());
      end
      7'b0110111, 7'b0010111: begin
        r = '0; r.imm = 3'd3; r.b = 2'd1;
        r.a = (op == 7'b0110111) ? 2'd3 : 2'd1;
        exp_q.push_back(r);
        exp_q.push_back(wb_rec());
      end
      default: trap = 1'b1;
    endcase
    if (trap) begin
      for (int k = 0; k < 12; k++) begin
        r = '0; r.ill = 1'b1;
        exp_q.push_back(r);
      end
    end
    return trap;
  endfunction

  task automatic checkOutput(input string name, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got funct=%h a=%0d b=%0d imm=%0d res=%0d adr=%0b ir=%0b pc=%0b reg=%0b mem=%0b ill=%0b, expected funct=%h a=%0d b=%0d imm=%0d res=%0d adr=%0b ir=%0b pc=%0b reg=%0b mem=%0b ill=%0b (t=%0t)",
               name, got.funct, got.a, got.b, got.imm, got.res, got.adr, got.irw, got.pcw, got.regw, got.memw, got.ill,
               want.funct, want.a, want.b, want.imm, want.res, want.adr, want.irw, want.pcw, want.regw, want.memw, want.ill, $time);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Cycle-by-cycle comparison against the model trace, away from the active edge
  always @(negedge clk) begin
    rec_t e;
    rec_t o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      seen.push_back(o);
      checkOutput("trace", o, e);
    end
  end

  // Runs one instruction from its FETCH cycle; called and returns at posedge+1.
  // Trapping instructions are recovered with a reset in the last trap cycle.
  task automatic applyStimulus(input logic [31:0] ins, input logic z);
    int n;
    bit trapped;
    seen.delete();
    bus.instr = ins;
    bus.zero  = z;
    trapped = build_trace(ins, z);
    n = exp_q.size();
    if (trapped) begin
      repeat (n - 1) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      repeat (n) @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checkValue("trace_drained", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] random_instr();
    logic [31:0] ins;
    logic [6:0]  ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011};
    ins = $urandom;
    case ($urandom_range(0, 11))
      10:      ins[6:0] = 7'h7F;
      11:      ins[6:0] = 7'(($urandom_range(0, 63) << 1) | 1);
      default: ins[6:0] = ops[$urandom_range(0, 9)];
    endcase
    return ins;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int mem_cnt;
    int reg_cnt;
    int strobe_cnt;
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.instr = 32'h0000_0013;
    bus.zero  = 1'b0;

    // Reset: strobes held low while reset is high, FETCH after release
    @(posedge clk);
    #1;
    checkValue("reset_strobes", int'({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}), 0);
    @(posedge clk);
    #1;
    checkValue("reset_illegal", int'(bus.illegal), 0);
    reset = 1'b0;
    #1;
    checkValue("fetch_ir_write", int'(bus.ir_write), 1);
    checkValue("fetch_src_b", int'(bus.alu_src_b_sel), 2);

    // add: 4 cycles, ADD code in EXEC_R, reg_write only in cycle 4
    applyStimulus(32'h003100B3, 1'b0);
    checkValue("add_cycles", seen.size(), 4);
    checkValue("add_funct", int'(seen[2].funct), 'h000);
    checkValue("add_regw_pattern", int'({seen[0].regw, seen[1].regw, seen[2].regw, seen[3].regw}), 1);

    applyStimulus(32'h403100B3, 1'b0);
    checkValue("sub_funct", int'(seen[2].funct), 'h100);
    applyStimulus(32'h4020D093, 1'b0);
    checkValue("srai_funct", int'(seen[2].funct), 'h105);
    applyStimulus(32'h40008093, 1'b0);
    checkValue("addi_b30_funct", int'(seen[2].funct), 'h000);

    // Branches: 3 cycles, taken decided by zero in the BRANCH cycle
    applyStimulus(32'h00208063, 1'b1);
    checkValue("beq_cycles", seen.size(), 3);
    checkValue("beq_taken_pcw", int'(seen[2].pcw), 1);
    checkValue("beq_taken_res", int'(seen[2].res), 1);
    applyStimulus(32'h00208063, 1'b0);
    checkValue("beq_not_taken_pcw", int'(seen[2].pcw), 0);
    applyStimulus(32'h0020D063, 1'b1);
    checkValue("bge_funct", int'(seen[2].funct), 'h002);
    checkValue("bge_taken_pcw", int'(seen[2].pcw), 1);

    // lw: 5 cycles; sw: single mem_write, no reg_write
    applyStimulus(32'h0000A103, 1'b0);
    checkValue("lw_cycles", seen.size(), 5);
    checkValue("lw_adr_sel", int'(seen[3].adr), 1);
    checkValue("lw_wb", int'({seen[4].res, seen[4].regw}), 5);
    applyStimulus(32'h0020A023, 1'b0);
    mem_cnt = 0;
    reg_cnt = 0;
    foreach (seen[k]) begin
      mem_cnt += int'(seen[k].memw);
      reg_cnt += int'(seen[k].regw);
    end
    checkValue("sw_mem_write_count", mem_cnt, 1);
    checkValue("sw_reg_write_count", reg_cnt, 0);

    applyStimulus(32'h000080E7, 1'b0);
    checkValue("jalr_funct", int'(seen[2].funct), 'h200);
    checkValue("jalr_jump_pcw", int'(seen[3].pcw), 1);
    checkValue("jalr_wb_regw", int'(seen[4].regw), 1);

    // Illegal opcode: illegal held through 12 trap cycles with no strobes
    applyStimulus(32'h0000007F, 1'b0);
    cnt = 0;
    strobe_cnt = 0;
    for (int k = 2; k < seen.size(); k++) begin
      cnt        += int'(seen[k].ill);
      strobe_cnt += int'(seen[k].irw) + int'(seen[k].pcw) + int'(seen[k].regw) + int'(seen[k].memw);
    end
    checkValue("trap_illegal_cycles", cnt, 12);
    checkValue("trap_strobes", strobe_cnt, 0);

    // Reset asserted during MEM_WRITE aborts the store
    bus.instr = 32'h0020A023;
    bus.zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("memwrite_before_reset", int'(bus.mem_write), 1);
    reset = 1'b1;
    #1;
    checkValue("memwrite_during_reset", int'(bus.mem_write), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkValue("fetch_after_reset", int'({bus.ir_write, bus.pc_write, bus.adr_sel}), 6);

    // Random instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(random_instr(), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle RISC-V RV32I control unit: the producer of the ALU's 10-bit function code and the consumer of its `zero` flag. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives datapath mux selects, register and memory write enables, and PC/IR write strobes, and evaluates branch conditions from `zero`. It sits between the instruction register and the datapath, one instance per core.

## Interface
- No parameters; widths fixed by RV32I.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 32: current instruction register contents, decoded fields opcode[6:0], funct3[14:12], funct7b5[30].
- `zero` in 1: ALU result-is-zero flag.
- `alu_funct` out 10: ALU function code.
- `alu_src_a_sel` out 2: 0 = PC, 1 = old PC, 2 = rs1 reg, 3 = constant 0.
- `alu_src_b_sel` out 2: 0 = rs2 reg, 1 = immediate, 2 = constant 4.
- `imm_sel` out 3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `result_sel` out 2: 0 = ALU result, 1 = ALUOut reg, 2 = memory data reg.
- `adr_sel` out 1: memory address, 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` out 1 each: write strobes.
- `illegal` out 1: sticky unsupported-opcode flag.

## Operation
- ALU function encoding:
  - `{jalr_mask, sub_sra, 5'b0, op3}`.
  - ADD = 0x000, SUB = 0x100, ADD&~1 = 0x200, SLL = 0x001, SLT = 0x002, SLTU = 0x003, XOR = 0x004, SRL = 0x005, SRA = 0x105, OR = 0x006, AND = 0x007.
- Function code per instruction class:
  - R-type (0110011): op3 = funct3; sub_sra = instr[30] when funct3 ∈ {000, 101}, else 0.
  - I-ALU (0010011): op3 = funct3; sub_sra = instr[30] only for funct3 = 101. ADDI never produces SUB.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JALR_ADDR, JUMP, UPPER, TRAP.
- FETCH: adr_sel = 0, ir_write = 1; ALU PC + 4 (a = 0, b = 2, ADD); result_sel = 0, pc_write = 1 → DECODE.
- DECODE: ALU old PC + imm (a = 1, b = 1, ADD), imm_sel B for branches, J for JAL, else I. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011, 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALR_ADDR
  - 0110111, 0010111 → UPPER
  - else → TRAP
- EXEC_R: a = 2, b = 0, R-type code → ALU_WB. EXEC_I: a = 2, b = 1, imm I, I-ALU code → ALU_WB.
- MEM_ADDR: a = 2, b = 1, ADD; imm S if store else I → MEM_WRITE (store) or MEM_READ (load).
- MEM_READ: adr_sel = 1 → MEM_WB. MEM_WB: result_sel = 2, reg_write = 1 → FETCH.
- MEM_WRITE: adr_sel = 1, mem_write = 1 → FETCH.
- BRANCH: a = 2, b = 0; pc_write = 1 with result_sel = 1 only when taken → FETCH.
  - BEQ: SUB, taken if zero. BNE: SUB, taken if !zero.
  - BLT: SLT, taken if !zero. BGE: SLT, taken if zero.
  - BLTU: SLTU, taken if !zero. BGEU: SLTU, taken if zero.
  - funct3 010/011 → TRAP.
- JALR_ADDR: a = 2, b = 1, imm I, code 0x200 → JUMP.
- JUMP: a = 1, b = 2, ADD; result_sel = 1, pc_write = 1 → ALU_WB (rd ← old PC + 4).
- UPPER: imm U, b = 1, ADD; a = 3 for LUI, a = 1 for AUIPC → ALU_WB.
- ALU_WB: result_sel = 1, reg_write = 1 → FETCH.
- TRAP: all strobes 0, illegal = 1; stays in TRAP until reset.
- Don't-care outputs in every state drive 0.

## Timing
- State register only; all outputs are Moore-decoded from state, except the BRANCH `pc_write`, which also depends on `zero` and funct3 (same cycle).
- `reset` high at an edge: state ← FETCH, illegal ← 0.
- While `reset` is high, all strobes are forced 0 combinationally, so no write occurs even in the reset cycle.
- Reset mid-instruction aborts it; no partial writeback.
- Cycles per instruction:
  - branch 3
  - R/I-ALU, store, JAL, LUI, AUIPC 4
  - load, JALR 5
- `instr` is sampled only in DECODE and later states; it must hold stable from the FETCH edge until the next FETCH.

## Test plan
- Reset, then `add` (0x003100B3) → states FETCH, DECODE, EXEC_R, ALU_WB; alu_funct 0x000 in EXEC_R; reg_write high only in cycle 4.
- `sub` (0x403100B3), then `srai` (0x4020D093), then `addi` with instr[30] = 1 (0x40008093) → codes 0x100, 0x105, 0x000.
- `beq` with zero = 1, then zero = 0 → pc_write in BRANCH is 1, then 0; 3 cycles each. `bge` with zero = 1 → taken, code 0x002.
- `lw` → 5 cycles, adr_sel = 1 in MEM_READ, result_sel = 2 and reg_write in MEM_WB. `sw` → mem_write high for exactly 1 cycle, no reg_write.
- `jalr` (0x000080E7) → code 0x200 in JALR_ADDR, pc_write in JUMP, reg_write in ALU_WB.
- Opcode 0x7F → TRAP, illegal = 1 held for 10+ cycles with all strobes 0. Reset asserted during MEM_WRITE → mem_write 0 that cycle, FETCH next.
